// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: requester slot state
// encoding, requester indices and the default RAM address width.
package ram_arbiter_pkg;

    localparam int AW_DEFAULT = 14;
    localparam int DW         = 8;

    localparam int REQ_VID = 0;
    localparam int REQ_CPU = 1;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_ISSUED = 2'd1,
        SLOT_ACK    = 2'd2
    } slot_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the video request, CPU request and RAM port signals.
// The arbiter uses the slave view; the surrounding blocks (or a bench)
// use the master view.
interface ram_arbiter_if #(
    parameter int AW = 14
);
    // video requester
    logic          vreq;
    logic [AW-1:0] va;
    logic          vack;
    logic [7:0]    vq;

    // CPU requester
    logic          creq;
    logic          cwe;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
    logic          cack;
    logic [7:0]    cq;
    logic          contend;

    // RAM port
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic [7:0]    ram_q;

    modport slave (
        input  vreq, va, creq, cwe, ca, cd, ram_q,
        output vack, vq, cack, cq, contend,
        output ram_ce, ram_we, ram_a, ram_d
    );

    modport master (
        output vreq, va, creq, cwe, ca, cd, ram_q,
        input  vack, vq, cack, cq, contend,
        input  ram_ce, ram_we, ram_a, ram_d
    );

endinterface

// File: rtl/ram_req_slot.sv
// Per-requester tracking of one outstanding RAM access.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   SLOT_IDLE   | no access outstanding, may be granted
//   SLOT_ISSUED | strobe on the RAM port this cycle
//   SLOT_ACK    | ack high this cycle, read data valid on ram_q
//
// The slot steps IDLE -> ISSUED -> ACK -> IDLE on consecutive edges;
// only a grant moves it out of IDLE, the other steps are unconditional,
// so a request still held during ACK is never seen as a new one.
module ram_req_slot
    import ram_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic grant,
    output logic eligible,
    output logic ack
);

    slot_state_t state;

    // Slot state machine with a registered ack pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SLOT_IDLE;
            ack   <= 1'b0;
        end else begin
            ack <= (state == SLOT_ISSUED);
            case (state)
                SLOT_IDLE:   if (grant) state <= SLOT_ISSUED;
                SLOT_ISSUED: state <= SLOT_ACK;
                SLOT_ACK:    state <= SLOT_IDLE;
                default:     state <= SLOT_IDLE;
            endcase
        end
    end

    assign eligible = (state == SLOT_IDLE);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the video fetcher
// (read-only, priority) and the CPU bus. Each requester gets a slot that
// tracks its outstanding access; this module picks the winner each edge,
// registers the RAM strobes/address/data and flags CPU requests that lost
// to video. Read data is a straight pass-through of ram_q gated by ack,
// which keeps the request inputs out of any combinational output path.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT
)(
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] ack;

    logic               ce_q;
    logic               we_q;
    logic [AW-1:0]      a_q;
    logic [DW-1:0]      d_q;
    logic               contend_q;

    // Fixed priority: video first, CPU only when video does not take the port.
    always_comb begin
        grant = '0;
        if (bus.vreq && eligible[REQ_VID]) begin
            grant[REQ_VID] = 1'b1;
        end else if (bus.creq && eligible[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        ram_req_slot u_slot (
            .clock    (clock),
            .reset    (reset),
            .grant    (grant[i]),
            .eligible (eligible[i]),
            .ack      (ack[i])
        );
    end

    // RAM port registers; address and write data hold when nothing is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            contend_q <= 1'b0;
        end else begin
            ce_q      <= |grant;
            we_q      <= grant[REQ_CPU] & bus.cwe;
            contend_q <= bus.creq & eligible[REQ_CPU] & grant[REQ_VID];
            if (grant[REQ_VID]) begin
                a_q <= bus.va;
                d_q <= '0;
            end else if (grant[REQ_CPU]) begin
                a_q <= bus.ca;
                d_q <= bus.cd;
            end
        end
    end

    assign bus.ram_ce  = ce_q;
    assign bus.ram_we  = we_q;
    assign bus.ram_a   = a_q;
    assign bus.ram_d   = d_q;
    assign bus.contend = contend_q;

    assign bus.vack = ack[REQ_VID];
    assign bus.cack = ack[REQ_CPU];
    assign bus.vq   = ack[REQ_VID] ? bus.ram_q : 8'h00;
    assign bus.cq   = ack[REQ_CPU] ? bus.ram_q : 8'h00;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ram_arbiter;

    localparam int AW = 14;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_arbiter_if #(.AW(AW)) bus ();

    ram_arbiter #(.AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:(1<<AW)-1];

    // Single-port RAM: write on ce&we, otherwise registered read on ce.
    always @(posedge clock) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
            else            bus.ram_q <= mem[bus.ram_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int vacks, ces, we_seen, bad_vq, cacks;
        bus.vreq = 1'b0; bus.va = '0;
        bus.creq = 1'b0; bus.cwe = 1'b0; bus.ca = '0; bus.cd = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;

        // reset state
        #1;
        tick(); tick();
        check("rst_ce", bus.ram_ce, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_a", bus.ram_a, 0);
        check("rst_d", bus.ram_d, 0);
        check("rst_acks", {bus.vack, bus.cack, bus.contend}, 0);
        reset = 1'b1;
        tick();

        // CPU write 0x0123 <= 0xA5
        bus.creq = 1'b1; bus.cwe = 1'b1; bus.ca = 14'h0123; bus.cd = 8'hA5;
        tick();
        check("wr_ce", bus.ram_ce, 1);
        check("wr_we", bus.ram_we, 1);
        check("wr_a", bus.ram_a, 14'h0123);
        check("wr_d", bus.ram_d, 8'hA5);
        check("wr_cack_early", bus.cack, 0);
        tick();
        check("wr_cack", bus.cack, 1);
        bus.creq = 1'b0;
        tick();
        check("wr_cack_gone", bus.cack, 0);
        check("wr_no_regrant", bus.ram_ce, 0);

        // CPU read back
        bus.creq = 1'b1; bus.cwe = 1'b0;
        tick();
        check("rd_ce", bus.ram_ce, 1);
        check("rd_we", bus.ram_we, 0);
        tick();
        check("rd_cack", bus.cack, 1);
        check("rd_cq", bus.cq, 8'hA5);
        bus.creq = 1'b0;
        tick();

        // simultaneous video and CPU reads
        bus.vreq = 1'b1; bus.va = 14'h0123;
        bus.creq = 1'b1; bus.cwe = 1'b0; bus.ca = 14'h0123;
        tick();
        check("sim_contend", bus.contend, 1);
        check("sim_ce1", bus.ram_ce, 1);
        check("sim_vack_early", bus.vack, 0);
        tick();
        check("sim_vack", bus.vack, 1);
        check("sim_vq", bus.vq, 8'hA5);
        check("sim_cack_early", bus.cack, 0);
        check("sim_contend_once", bus.contend, 0);
        check("sim_ce2", bus.ram_ce, 1);
        bus.vreq = 1'b0;
        tick();
        check("sim_cack", bus.cack, 1);
        check("sim_cq", bus.cq, 8'hA5);
        check("sim_vack_gone", bus.vack, 0);
        bus.creq = 1'b0;
        tick();

        // CPU holds a read request for 6 edges: grants at E1 and E4
        bus.creq = 1'b1; bus.cwe = 1'b0; bus.ca = 14'h0123;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("hold_ce_e%0d", i), bus.ram_ce, (i == 1 || i == 4) ? 1 : 0);
            check($sformatf("hold_cack_e%0d", i), bus.cack, (i == 2 || i == 5) ? 1 : 0);
        end
        bus.creq = 1'b0;
        tick();

        // both requesters held: V, C, idle, V, C, idle, ...
        mem[14'h0010] = 8'h5A;
        mem[14'h0020] = 8'h3C;
        bus.vreq = 1'b1; bus.va = 14'h0010;
        bus.creq = 1'b1; bus.cwe = 1'b0; bus.ca = 14'h0020;
        for (int i = 1; i <= 9; i++) begin
            tick();
            case (i % 3)
                1: begin
                    check($sformatf("il_ce_e%0d", i), bus.ram_ce, 1);
                    check($sformatf("il_a_e%0d", i), bus.ram_a, 14'h0010);
                end
                2: begin
                    check($sformatf("il_ce_e%0d", i), bus.ram_ce, 1);
                    check($sformatf("il_a_e%0d", i), bus.ram_a, 14'h0020);
                    check($sformatf("il_vq_e%0d", i), {bus.vack, bus.vq}, {1'b1, 8'h5A});
                end
                default: begin
                    check($sformatf("il_ce_e%0d", i), bus.ram_ce, 0);
                    check($sformatf("il_cq_e%0d", i), {bus.cack, bus.cq}, {1'b1, 8'h3C});
                end
            endcase
            check($sformatf("il_contend_e%0d", i), bus.contend, (i == 1) ? 1 : 0);
        end
        bus.vreq = 1'b0; bus.creq = 1'b0;
        tick(); tick();

        // video only, 100 back-to-back reads
        bus.vreq = 1'b1; bus.va = 14'h0123;
        vacks = 0; ces = 0; we_seen = 0; bad_vq = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.ram_we) we_seen++;
            if (bus.ram_ce) ces++;
            if (bus.vack) begin
                vacks++;
                if (bus.vq !== 8'hA5) bad_vq++;
            end
        end
        bus.vreq = 1'b0;
        check("vid_we_never", we_seen, 0);
        check("vid_grants", ces, 100);
        check("vid_acks", vacks, 100);
        check("vid_data", bad_vq, 0);
        tick(); tick();

        // reset while a CPU read is issued
        bus.creq = 1'b1; bus.cwe = 1'b0; bus.ca = 14'h0123;
        tick();
        check("rio_ce_before", bus.ram_ce, 1);
        reset = 1'b0;
        bus.creq = 1'b0;
        #1;
        check("rio_ce", bus.ram_ce, 0);
        check("rio_a", bus.ram_a, 0);
        check("rio_we_d", {bus.ram_we, bus.ram_d}, 0);
        check("rio_acks", {bus.vack, bus.cack, bus.contend, bus.vq, bus.cq}, 0);
        tick(); tick();
        reset = 1'b1;
        cacks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.cack) cacks++;
        end
        check("rio_no_cack", cacks, 0);
        bus.creq = 1'b1; bus.cwe = 1'b0; bus.ca = 14'h0123;
        tick();
        check("rio_regrant", bus.ram_ce, 1);
        check("rio_regrant_a", bus.ram_a, 14'h0123);
        tick();
        check("rio_cq", {bus.cack, bus.cq}, {1'b1, 8'hA5});
        bus.creq = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
